// File: rtl/trap_pkg.sv
// trap_pkg: shared constants for the machine-mode trap unit.
// Holds CSR addresses, synchronous exception cause codes, SYSTEM funct12
// encodings, mstatus bit positions and the redirect FSM state encoding.
package trap_pkg;

   // CSR address map
   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MIE     = 12'h304;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MTVAL   = 12'h343;
   localparam logic [11:0] CSR_MIP     = 12'h344;

   // Synchronous exception cause codes (ecall code is a top-level parameter)
   localparam int CAUSE_FETCH_MISALIGN = 0;
   localparam int CAUSE_ILLEGAL        = 2;
   localparam int CAUSE_BREAKPOINT     = 3;
   localparam int CAUSE_LOAD_MISALIGN  = 4;
   localparam int CAUSE_STORE_MISALIGN = 6;

   // i_EXCOp encodings
   localparam logic [1:0] EXC_NONE    = 2'b00;
   localparam logic [1:0] EXC_SYSTEM  = 2'b01;
   localparam logic [1:0] EXC_ILLEGAL = 2'b10;

   // SYSTEM instruction funct12 values (funct3 == 000)
   localparam logic [11:0] F12_ECALL  = 12'h000;
   localparam logic [11:0] F12_EBREAK = 12'h001;
   localparam logic [11:0] F12_MRET   = 12'h302;

   // mstatus bit positions
   localparam int MSTATUS_MIE  = 3;
   localparam int MSTATUS_MPIE = 7;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_ENTER  = 2'd1,
      ST_RETURN = 2'd2
   } trap_state_t;

endpackage

// File: rtl/trap_priority_encoder.sv
// trap_priority_encoder: picks the single winning event among pending
// interrupts, synchronous exceptions and mret.
// Purely combinational. Ports: irq_pend (enabled, globally unmasked irqs),
// per-exception flags and mret in; evt_vld/evt_intr/evt_mret/evt_tval/evt_code out.
module trap_priority_encoder
   import trap_pkg::*;
#(
   parameter int NUM_IRQ        = 4,
   parameter int IRQ_CAUSE_BASE = 16,
   parameter int ECALL_CAUSE    = 11,
   parameter int CODE_W         = 31
) (
   input  logic [NUM_IRQ-1:0] irq_pend,
   input  logic               fetch_misalign,
   input  logic               illegal,
   input  logic               ebreak,
   input  logic               ecall,
   input  logic               load_misalign,
   input  logic               store_misalign,
   input  logic               mret,
   output logic               evt_vld,
   output logic               evt_intr,
   output logic               evt_mret,
   output logic               evt_tval,   // event reports i_tval in mtval
   output logic [CODE_W-1:0]  evt_code
);

   always_comb begin
      evt_vld  = 1'b0;
      evt_intr = 1'b0;
      evt_mret = 1'b0;
      evt_tval = 1'b0;
      evt_code = '0;
      if (|irq_pend) begin
         evt_vld  = 1'b1;
         evt_intr = 1'b1;
         // Scan from the top down so the lowest set index is the last write.
         for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (irq_pend[i]) begin
               evt_code = CODE_W'(IRQ_CAUSE_BASE + i);
            end
         end
      end else if (fetch_misalign) begin
         evt_vld  = 1'b1;
         evt_tval = 1'b1;
         evt_code = CODE_W'(CAUSE_FETCH_MISALIGN);
      end else if (illegal) begin
         evt_vld  = 1'b1;
         evt_tval = 1'b1;
         evt_code = CODE_W'(CAUSE_ILLEGAL);
      end else if (ebreak) begin
         evt_vld  = 1'b1;
         evt_code = CODE_W'(CAUSE_BREAKPOINT);
      end else if (ecall) begin
         evt_vld  = 1'b1;
         evt_code = CODE_W'(ECALL_CAUSE);
      end else if (load_misalign) begin
         evt_vld  = 1'b1;
         evt_tval = 1'b1;
         evt_code = CODE_W'(CAUSE_LOAD_MISALIGN);
      end else if (store_misalign) begin
         evt_vld  = 1'b1;
         evt_tval = 1'b1;
         evt_code = CODE_W'(CAUSE_STORE_MISALIGN);
      end else if (mret) begin
         evt_vld  = 1'b1;
         evt_mret = 1'b1;
      end
   end

endmodule

// File: rtl/trap_controller.sv
// trap_controller: machine-mode trap unit. Decodes SYSTEM ops, collects
// misalignment faults and interrupts, owns the M-mode trap CSRs and drives a
// two-phase flush/redirect FSM (event in cycle N, redirect N+1, accept N+2).
// Ports: i_clk/i_rst (sync, active-high); commit-point instruction info
// (i_valid, i_pc, i_EXCOp, i_funct3, i_funct12, misalign flags, i_tval);
// i_irq level interrupts; CSR write port (i_csrWe/i_csrAddr/i_csrWdata) and
// combinational read o_csrRdata; o_flush/o_redirect/o_redirectPc/o_trapTaken/o_mret.
// Optional: VECTORED_MTVEC_EN enables vectored interrupt targets via mtvec[0].
module trap_controller
   import trap_pkg::*;
#(
   parameter int              XLEN           = 32,
   parameter int              NUM_IRQ        = 4,
   parameter int              IRQ_CAUSE_BASE = 16,
   parameter int              ECALL_CAUSE    = 11,
   parameter logic [XLEN-1:0] RESET_MTVEC    = 32'h0000_0100
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_valid,
   input  logic [XLEN-1:0]    i_pc,
   input  logic [1:0]         i_EXCOp,
   input  logic [2:0]         i_funct3,
   input  logic [11:0]        i_funct12,
   input  logic               i_fetchMisalign,
   input  logic               i_loadMisalign,
   input  logic               i_storeMisalign,
   input  logic [XLEN-1:0]    i_tval,
   input  logic [NUM_IRQ-1:0] i_irq,
   input  logic               i_csrWe,
   input  logic [11:0]        i_csrAddr,
   input  logic [XLEN-1:0]    i_csrWdata,
   output logic [XLEN-1:0]    o_csrRdata,
   output logic               o_flush,
   output logic               o_redirect,
   output logic [XLEN-1:0]    o_redirectPc,
   output logic               o_trapTaken,
   output logic               o_mret
);

   localparam int CODE_W = XLEN - 1;

`ifdef VECTORED_MTVEC_EN
   // mtvec[0] selects vectored mode; mtvec[1] is hardwired low.
   localparam logic [XLEN-1:0] MTVEC_MASK = ~XLEN'(2);
`else
   localparam logic [XLEN-1:0] MTVEC_MASK = ~XLEN'(3);
`endif

   trap_state_t     state;
   logic            mst_mie;
   logic            mst_mpie;
   logic [XLEN-1:0] mie_q;
   logic [XLEN-1:0] mtvec_q;
   logic [XLEN-1:0] mepc_q;
   logic [XLEN-1:0] mcause_q;
   logic [XLEN-1:0] mtval_q;

   // ---------------------------------------------------------------
   // Decode; everything is gated by "RUN with a committing instruction"
   // so the encoder only ever reports an event that will be accepted.
   // ---------------------------------------------------------------
   logic run_vld;
   logic sys_zero;
   logic dec_ecall, dec_ebreak, dec_mret, dec_illegal;
   logic [NUM_IRQ-1:0] irq_pend;

   assign run_vld     = (state == ST_RUN) && i_valid;
   assign sys_zero    = (i_EXCOp == EXC_SYSTEM) && (i_funct3 == 3'b000);
   assign dec_ecall   = sys_zero && (i_funct12 == F12_ECALL);
   assign dec_ebreak  = sys_zero && (i_funct12 == F12_EBREAK);
   assign dec_mret    = sys_zero && (i_funct12 == F12_MRET);
   assign dec_illegal = (i_EXCOp == EXC_ILLEGAL) ||
                        (sys_zero && !dec_ecall && !dec_ebreak && !dec_mret);
   assign irq_pend    = (i_irq & mie_q[NUM_IRQ-1:0]) & {NUM_IRQ{mst_mie & run_vld}};

   logic              evt_vld, evt_intr, evt_mret, evt_tval;
   logic [CODE_W-1:0] evt_code;

   trap_priority_encoder #(
      .NUM_IRQ        (NUM_IRQ),
      .IRQ_CAUSE_BASE (IRQ_CAUSE_BASE),
      .ECALL_CAUSE    (ECALL_CAUSE),
      .CODE_W         (CODE_W)
   ) u_prio (
      .irq_pend       (irq_pend),
      .fetch_misalign (run_vld & i_fetchMisalign),
      .illegal        (run_vld & dec_illegal),
      .ebreak         (run_vld & dec_ebreak),
      .ecall          (run_vld & dec_ecall),
      .load_misalign  (run_vld & i_loadMisalign),
      .store_misalign (run_vld & i_storeMisalign),
      .mret           (run_vld & dec_mret),
      .evt_vld        (evt_vld),
      .evt_intr       (evt_intr),
      .evt_mret       (evt_mret),
      .evt_tval       (evt_tval),
      .evt_code       (evt_code)
   );

   logic take_trap, take_mret, csr_wr;
   assign take_trap = evt_vld && !evt_mret;
   assign take_mret = evt_vld && evt_mret;
   // An instruction that raises an event never commits, so its CSR write is dropped.
   assign csr_wr    = run_vld && i_csrWe && !evt_vld;

   // ---------------------------------------------------------------
   // Targets
   // ---------------------------------------------------------------
   logic [XLEN-1:0] mtvec_base, mepc_rd, trap_tgt;
   assign mtvec_base = {mtvec_q[XLEN-1:2], 2'b00};
   assign mepc_rd    = {mepc_q[XLEN-1:2], 2'b00};

`ifdef VECTORED_MTVEC_EN
   assign trap_tgt = (mtvec_q[0] && evt_intr) ? mtvec_base + (XLEN'(evt_code) << 2)
                                              : mtvec_base;
`else
   assign trap_tgt = mtvec_base;
`endif

   // ---------------------------------------------------------------
   // CSR state
   // ---------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         mst_mie  <= 1'b0;
         mst_mpie <= 1'b0;
         mie_q    <= '0;
         mtvec_q  <= RESET_MTVEC & MTVEC_MASK;
         mepc_q   <= '0;
         mcause_q <= '0;
         mtval_q  <= '0;
      end else if (take_trap) begin
         mepc_q   <= i_pc;
         mcause_q <= {evt_intr, evt_code};
         mtval_q  <= evt_tval ? i_tval : '0;
         mst_mpie <= mst_mie;
         mst_mie  <= 1'b0;
      end else if (take_mret) begin
         mst_mie  <= mst_mpie;
         mst_mpie <= 1'b1;
      end else if (csr_wr) begin
         case (i_csrAddr)
            CSR_MSTATUS: begin
               mst_mie  <= i_csrWdata[MSTATUS_MIE];
               mst_mpie <= i_csrWdata[MSTATUS_MPIE];
            end
            CSR_MIE:    mie_q    <= i_csrWdata;
            CSR_MTVEC:  mtvec_q  <= i_csrWdata & MTVEC_MASK;
            CSR_MEPC:   mepc_q   <= i_csrWdata;
            CSR_MCAUSE: mcause_q <= i_csrWdata;
            CSR_MTVAL:  mtval_q  <= i_csrWdata;
            default: ;  // mip is read-only; unmapped writes vanish
         endcase
      end
   end

   // ---------------------------------------------------------------
   // Redirect FSM with registered outputs
   // ---------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state        <= ST_RUN;
         o_flush      <= 1'b0;
         o_redirect   <= 1'b0;
         o_redirectPc <= '0;
         o_trapTaken  <= 1'b0;
         o_mret       <= 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               o_flush      <= 1'b0;
               o_redirect   <= 1'b0;
               o_redirectPc <= '0;
               o_trapTaken  <= 1'b0;
               o_mret       <= 1'b0;
               if (take_trap) begin
                  state        <= ST_ENTER;
                  o_flush      <= 1'b1;
                  o_redirect   <= 1'b1;
                  o_redirectPc <= trap_tgt;
                  o_trapTaken  <= 1'b1;
               end else if (take_mret) begin
                  state        <= ST_RETURN;
                  o_flush      <= 1'b1;
                  o_redirect   <= 1'b1;
                  o_redirectPc <= mepc_rd;
                  o_mret       <= 1'b1;
               end
            end
            default: begin
               // ENTER / RETURN: single redirect cycle, commit port ignored.
               state        <= ST_RUN;
               o_flush      <= 1'b0;
               o_redirect   <= 1'b0;
               o_redirectPc <= '0;
               o_trapTaken  <= 1'b0;
               o_mret       <= 1'b0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------
   // CSR read
   // ---------------------------------------------------------------
   always_comb begin
      o_csrRdata = '0;
      case (i_csrAddr)
         CSR_MSTATUS: begin
            o_csrRdata[MSTATUS_MIE]  = mst_mie;
            o_csrRdata[MSTATUS_MPIE] = mst_mpie;
         end
         CSR_MIE:    o_csrRdata = mie_q;
         CSR_MTVEC:  o_csrRdata = mtvec_q;
         CSR_MEPC:   o_csrRdata = mepc_rd;
         CSR_MCAUSE: o_csrRdata = mcause_q;
         CSR_MTVAL:  o_csrRdata = mtval_q;
         CSR_MIP:    o_csrRdata = XLEN'(i_irq);
         default:    o_csrRdata = '0;
      endcase
   end

endmodule
